// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: valid/ready flow controller for a chain of externally
// instantiated, enable-gated data registers. Tracks one valid bit per stage,
// drives per-stage load enables so data advances and bubbles collapse, and
// offers a valid/ready handshake at both ends.
//
// Optional feature macro: PIPE_STAGE_CTRL_STALL_CNT_EN
//   defined   -> stall_cnt_o port and a saturating 32-bit output-stall counter
//   undefined -> port and counter absent, all other behaviour identical
module pipe_stage_ctrl #(
  parameter  int unsigned Stages = 4,
  localparam int unsigned OccW   = $clog2(Stages + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [Stages-1:0] stage_en_o,
  output logic [Stages-1:0] stage_valid_o,
  output logic [OccW-1:0]   occupancy_o
`ifdef PIPE_STAGE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  // Number of set bits in a stage-valid vector; result range is 0..Stages.
  function automatic logic [OccW-1:0] popcount(input logic [Stages-1:0] bits);
    logic [OccW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(Stages); i++) begin
      cnt = cnt + OccW'(bits[i]);
    end
    return cnt;
  endfunction

  logic [Stages-1:0] v_q;
  logic [Stages-1:0] v_d;
  logic [OccW-1:0]   occ_q;
  logic [Stages-1:0] src_s;
  logic [Stages-1:0] adv_s;
  logic [Stages-1:0] en_s;

  // Source valid per stage and the advance ripple from the output end:
  // a stage may load when it is empty or when the stage after it advances.
  always_comb begin
    src_s    = '0;
    adv_s    = '0;
    src_s[0] = in_valid_i;
    for (int k = 1; k < int'(Stages); k++) begin
      src_s[k] = v_q[k-1];
    end
    adv_s[Stages-1] = ~v_q[Stages-1] | out_ready_i;
    for (int k = int'(Stages) - 2; k >= 0; k--) begin
      adv_s[k] = ~v_q[k] | adv_s[k+1];
    end
  end

  // Load enables only for valid data moving in, and next-state valid bits;
  // a flush suppresses every enable and empties the pipe.
  always_comb begin
    en_s = '0;
    v_d  = v_q;
    if (flush_i) begin
      en_s = '0;
      v_d  = '0;
    end else begin
      en_s = adv_s & src_s;
      for (int k = 0; k < int'(Stages); k++) begin
        if (adv_s[k]) begin
          v_d[k] = src_s[k];
        end else begin
          v_d[k] = v_q[k];
        end
      end
    end
  end

  // Valid-bit and occupancy registers; occupancy tracks the same edge as v.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= popcount(v_d);
    end
  end

`ifdef PIPE_STAGE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count cycles where the last stage holds data that downstream refuses;
  // saturates, and survives a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v_q[Stages-1] && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign in_ready_o    = adv_s[0] & ~flush_i;
  assign out_valid_o   = v_q[Stages-1];
  assign stage_en_o    = en_s;
  assign stage_valid_o = v_q;
  assign occupancy_o   = occ_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Testbench for pipe_stage_ctrl: drives the controller plus a bench-side chain
// of enable-gated data registers. A reference model tracks in-flight items by
// stage position; a scoreboard queue of accepted data is checked by a
// separate monitor whenever the last stage transfers out.
module tb_pipe_stage_ctrl;
  localparam int S  = 4;
  localparam int OW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          srst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [S-1:0]  en, sv;
  logic [OW-1:0] occ;
  logic [15:0]   in_data;
  logic [15:0]   dreg [S];
`ifdef PIPE_STAGE_CTRL_STALL_CNT_EN
  logic [31:0]   stall;
  logic [31:0]   exp_stall = 32'd0;
`endif

  int          n_vec = 0;
  int          n_mis = 0;
  int          pos_q[$];   // stage index of each in-flight item, oldest first
  int          np_q[$];    // positions after the coming edge (-1 = leaves)
  logic [15:0] exp_q[$];   // scoreboard: accepted data in order
  bit          acc;
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.Stages(S)) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .stage_en_o   (en),
    .stage_valid_o(sv),
    .occupancy_o  (occ)
`ifdef PIPE_STAGE_CTRL_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall)
`endif
  );

  // Enable-gated datapath registers, as the controller expects outside it.
  always @(posedge clk) begin
    if (en[0]) dreg[0] <= in_data;
    for (int k = 1; k < S; k++) begin
      if (en[k]) dreg[k] <= dreg[k-1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must deliver the oldest accepted item.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready && !srst) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", 64'(dreg[S-1]), 64'(mon_exp));
      end
    end
  end

  // Items move forward one stage per cycle, never into or past the item
  // ahead; the oldest item leaves from the last stage when downstream is ready.
  task automatic compute_next(input bit ordy);
    int lim;
    int p;
    np_q = {};
    lim  = S - 1;
    for (int i = 0; i < pos_q.size(); i++) begin
      if (i == 0 && pos_q[0] == S - 1 && ordy) begin
        np_q.push_back(-1);
      end else begin
        p = pos_q[i] + 1;
        if (p > lim) p = lim;
        np_q.push_back(p);
        lim = p - 1;
      end
    end
  endtask

  task automatic step(input bit iv, input bit ordy, input bit fl, input bit rs);
    logic [S-1:0] e_en;
    logic [S-1:0] e_sv;
    bit           e_rdy;
    int           nq[$];
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    srst      = rs;
    in_data   = 16'($urandom);
    #1;
    e_sv = '0;
    foreach (pos_q[i]) e_sv[pos_q[i]] = 1'b1;
    e_rdy = !fl && !(pos_q.size() == S && !ordy);
    compute_next(ordy);
    e_en = '0;
    foreach (np_q[i]) begin
      if (np_q[i] >= 0 && np_q[i] != pos_q[i]) e_en[np_q[i]] = 1'b1;
    end
    acc = iv && e_rdy;
    if (acc) e_en[0] = 1'b1;
    if (fl) e_en = '0;
    chk("stage_valid", 64'(sv), 64'(e_sv));
    chk("occupancy", 64'(occ), 64'(pos_q.size()));
    chk("out_valid", 64'(out_valid), 64'(e_sv[S-1]));
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("stage_en", 64'(en), 64'(e_en));
`ifdef PIPE_STAGE_CTRL_STALL_CNT_EN
    chk("stall_cnt", 64'(stall), 64'(exp_stall));
`endif
    if (acc && !rs) exp_q.push_back(in_data);
    @(posedge clk);
`ifdef PIPE_STAGE_CTRL_STALL_CNT_EN
    if (rs) exp_stall = 32'd0;
    else if (e_sv[S-1] && !ordy && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
    if (rs || fl) begin
      pos_q = {};
      exp_q = {};
    end else begin
      nq = {};
      foreach (np_q[i]) if (np_q[i] >= 0) nq.push_back(np_q[i]);
      if (acc) nq.push_back(0);
      pos_q = nq;
    end
    #1;
  endtask

  initial begin
    srst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 16'd0;
    // first reset edge brings state out of X; second reset cycle is checked
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    // streaming: ten items with downstream always ready
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, 1'b0, 1'b0);
    // backpressure fill: six offers, then drain
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  step(1'b0, 1'b1, 1'b0, 1'b0);
    // bubble collapse: valid,0,valid,0 with output stalled
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 1'b0, 1'b0);
    // fill to full, stall a while, then flush with input offered
    for (int i = 0; i < 7; i++)  step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // refill, then flush together with reset
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
    end
    for (int i = 0; i < 2 * S; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
